uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter LOCK_TIMEOUT, default 65535, idle cycles before a packet lock is forcibly released.
REQ-003 Port clk, input, 1, single system clock; all logic on its posedge.
REQ-004 Port resetn, input, 1, asynchronous active-low reset.
REQ-005 Ports req0_valid and req1_valid, input, 1 each, requester has a byte.
REQ-006 Ports req0_data and req1_data, input, 8 each, byte to send.
REQ-007 Ports req0_last and req1_last, input, 1 each, byte ends the requester's packet.
REQ-008 Ports req0_ready and req1_ready, output, 1 each, one-cycle byte-accept strobe.
REQ-009 Port grant, output, 2, one-hot owner of the transmitter; 2'b00 when unowned.
REQ-010 Port busy, output, 1, serializer is shifting a frame.
REQ-011 Port UART_TXD, output, 1, serial line, 8N1, LSB first, idle high.

Function
REQ-012 Arbitration SHALL occur only when grant==2'b00; the winner is the valid requester, and on a tie the requester that did not win last.
REQ-013 The round-robin pointer SHALL update only when a packet ends (last byte accepted or timeout release), not per byte.
REQ-014 Grant SHALL be registered one cycle after arbitration and held until the owner's byte with last=1 is accepted.
REQ-015 Accept SHALL occur when the owner's valid=1, busy=0, and no frame is starting; the owner's ready SHALL pulse high for exactly that cycle.
REQ-016 The non-owner's ready SHALL remain 0.
REQ-017 Requesters SHALL hold valid, data and last stable until ready.
REQ-018 The serializer states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE->START on accept; the start bit (0) SHALL appear on UART_TXD the cycle after accept.
REQ-020 Each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-021 Bit sequence: START, DATA[0]..DATA[7], STOP (1); then STOP->IDLE.
REQ-022 busy=1 from the cycle after accept through the last STOP cycle.
REQ-023 The earliest next accept SHALL be the first IDLE cycle, giving exactly one idle-high cycle between back-to-back frames.
REQ-024 Lock timeout: while granted, busy=0 and owner valid=0, a counter SHALL increment. It SHALL clear on any accept.
REQ-025 When the counter reaches LOCK_TIMEOUT, grant SHALL go to 00 and the pointer SHALL update.
REQ-026 A packet end with the other requester valid SHALL switch ownership: grant goes 00 for one cycle, then to the other requester.
REQ-027 Simultaneous first-time request after reset: requester 0 SHALL win (pointer resets to favour 0).
REQ-028 The bit counter SHALL be 3 bits and wrap only on leaving DATA.
REQ-029 The baud counter SHALL be wide enough for CLKS_PER_BIT-1.

Reset
REQ-030 Asserting resetn SHALL set the following at once: UART_TXD=1, busy=0, grant=00, ready=0, state IDLE, all counters 0, pointer favouring req0.
REQ-031 Reset mid-frame SHALL abort the frame immediately, leaving the line high; the aborted byte is not retransmitted.
REQ-032 Deassertion is synchronised externally; no output SHALL change before the first posedge after release.

Structure
REQ-033 A shared package SHALL hold the serializer state encoding (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT.
REQ-034 The serializer SHALL be one sub-module, uart_tx_serializer, with ports: clk, resetn, start, data[7:0], busy, txd.
REQ-035 Arbitration, lock and timeout logic SHALL live in the top module.

Verification
REQ-036 Use CLKS_PER_BIT=4 and LOCK_TIMEOUT=16 in sim. Test: req0 sends 8'h55 with last=1 -> req0_ready one cycle; UART_TXD=0,1,0,1,0,1,0,1,0,1, each 4 cycles; busy=1 for 40 cycles.
REQ-037 Test: req0 and req1 both valid after reset, one byte each, last=1 -> req0 frame first, then req1; one idle-high cycle between frames.
REQ-038 Test: req0 sends 3-byte packet 8'h41,8'h42,8'h43 (last on 8'h43) while req1 is valid throughout -> three req0 frames, then req1 frame; grant stays 01 across the packet.
REQ-039 Test: req0 sends one byte with last=0, then drops valid -> grant clears after 16 idle cycles; waiting req1 is then granted.
REQ-040 Test: assert resetn low during DATA bit 3 -> UART_TXD=1, busy=0, grant=00 immediately; a new byte after release transmits correctly.
REQ-041 Test: req1 alone sends 8'hFF -> only start bit low; 9 high bit-times follow; the checker decodes 8'hFF.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: serializer state encoding and default timing constants
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_LOCK_TIMEOUT = 65535;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 LSB-first transmitter, idle high, one frame per start strobe
module uart_tx_serializer
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  tx_state_t r_state, w_next;
  logic [BW-1:0] r_baud;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic w_tick;
  assign w_tick = r_baud == BW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = start ? ST_START : ST_IDLE;
      ST_START: w_next = w_tick ? ST_DATA : ST_START;
      ST_DATA:  w_next = (w_tick && r_bit == 3'd7) ? ST_STOP : ST_DATA;
      ST_STOP:  w_next = w_tick ? ST_IDLE : ST_STOP;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_baud <= (r_state == ST_IDLE || w_tick) ? '0 : r_baud + 1'b1;
      if (r_state == ST_IDLE && start) r_shift <= data;
      else if (r_state == ST_DATA && w_tick) r_shift <= r_shift >> 1;
      // the 3-bit counter wraps from 7 to 0 exactly as DATA is left
      if (r_state == ST_DATA && w_tick) r_bit <= r_bit + 1'b1;
    end
  end
  always_comb begin
    busy = r_state != ST_IDLE;
    txd  = (r_state == ST_START) ? 1'b0 : (r_state == ST_DATA) ? r_shift[0] : 1'b1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter for two byte requesters
// sharing one UART transmitter, with an idle-lock timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       UART_TXD
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  logic [1:0] r_grant;
  logic r_ptr;
  logic [TW-1:0] r_lock;
  logic w_busy, w_own_valid, w_own_last, w_accept, w_idle, w_timeout, w_end;
  logic [7:0] w_data;
  logic [1:0] w_win;
  assign w_own_valid = (r_grant[0] & req0_valid) | (r_grant[1] & req1_valid);
  assign w_own_last  = r_grant[1] ? req1_last : req0_last;
  assign w_data      = r_grant[1] ? req1_data : req0_data;
  // a new frame can only start from an idle serializer, so !busy also covers "no frame starting"
  assign w_accept    = w_own_valid & ~w_busy;
  assign w_idle      = |r_grant & ~w_busy & ~w_own_valid;
  assign w_timeout   = w_idle && r_lock == TW'(LOCK_TIMEOUT - 1);
  assign w_end       = (w_accept & w_own_last) | w_timeout;
  assign w_win       = (req0_valid & req1_valid) ? (r_ptr ? 2'b10 : 2'b01) : {req1_valid, req0_valid};
  assign req0_ready  = w_accept & r_grant[0];
  assign req1_ready  = w_accept & r_grant[1];
  assign grant       = r_grant;
  assign busy        = w_busy;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant <= 2'b00;
      r_ptr   <= 1'b0;
      r_lock  <= '0;
    end else begin
      r_grant <= w_end ? 2'b00 : (r_grant == 2'b00) ? w_win : r_grant;
      if (w_end) r_ptr <= r_grant[0];
      r_lock <= (w_accept | w_timeout | ~|r_grant) ? '0 : w_idle ? r_lock + 1'b1 : r_lock;
    end
  end
  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk    (clk),
    .resetn (resetn),
    .start  (w_accept),
    .data   (w_data),
    .busy   (w_busy),
    .txd    (UART_TXD)
  );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks drive requesters; a line monitor decodes
// frames and checks them against a queue of expected bytes.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, busy, UART_TXD;
  logic [1:0] grant;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, frames_done = 0, last_start = 0, prev_start = 0, n_ready0 = 0, n_ready1 = 0;
  logic [7:0] q_exp[$];
  logic [39:0] m_samp;
  int m_cnt = 0;
  bit m_active = 0, m_busy_ok = 0;

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .grant(grant), .busy(busy), .UART_TXD(UART_TXD)
  );

  always #5 clk = ~clk;

  task automatic check_frame();
    logic [9:0] b;
    logic [3:0] g;
    logic [7:0] e;
    bit ok;
    ok = m_busy_ok && UART_TXD === 1'b1 && busy === 1'b0;
    for (int k = 0; k < 10; k++) begin
      g = m_samp[4*k +: 4];
      if (g !== 4'h0 && g !== 4'hF) ok = 0;
      b[k] = g[0];
    end
    if (b[0] !== 1'b0 || b[9] !== 1'b1) ok = 0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frame_shape: samples=%h busy_ok=%0d gap_txd=%b gap_busy=%b, required 4-cycle bits, start 0, stop 1, busy through frame, idle gap", m_samp, m_busy_ok, UART_TXD, busy);
    end
    n_checks++;
    if (q_exp.size() == 0) begin
      n_fail++;
      $display("FAIL frame_byte: got %h, required no frame (queue empty)", b[8:1]);
    end else begin
      e = q_exp.pop_front();
      if (b[8:1] !== e) begin
        n_fail++;
        $display("FAIL frame_byte: got %h, required %h", b[8:1], e);
      end
    end
    frames_done++;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (req0_ready === 1'b1) n_ready0++;
    if (req1_ready === 1'b1) n_ready1++;
    if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
      n_checks++;
      if ({req1_ready, req0_ready} !== grant || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_vs_grant: ready=%b%b grant=%b busy=%b, required ready equal to grant with busy=0", req1_ready, req0_ready, grant, busy);
      end
    end
    if (!resetn) m_active = 0;
    else begin
      if (!m_active && UART_TXD === 1'b0) begin
        m_active = 1; m_cnt = 0; m_busy_ok = 1; prev_start = last_start; last_start = cyc;
      end
      if (m_active) begin
        if (m_cnt < 40) begin
          m_samp[m_cnt] = UART_TXD;
          m_busy_ok = m_busy_ok && busy === 1'b1;
          m_cnt++;
        end else begin
          check_frame();
          m_active = 0;
        end
      end
    end
  end

  task automatic drive(input bit r, input logic [7:0] d, input logic l);
    bit got;
    @(posedge clk) #1;
    if (r) begin req1_valid = 1; req1_data = d; req1_last = l; end
    else begin req0_valid = 1; req0_data = d; req0_last = l; end
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = r ? req1_ready : req0_ready;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL ready_timeout: requester %0d byte %h got no ready, required ready within 300 cycles", r, d);
    end
    @(posedge clk) #1;
    if (r) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 600 && frames_done < n; i++) @(negedge clk);
    n_checks++;
    if (frames_done < n) begin
      n_fail++;
      $display("FAIL frame_timeout: frames=%0d, required %0d", frames_done, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3 resetn = 0;
    #1;
    n_checks++;
    if (UART_TXD !== 1'b1 || busy !== 1'b0 || grant !== 2'b00 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: txd=%b busy=%b grant=%b ready=%b%b, required 1 0 00 00", UART_TXD, busy, grant, req1_ready, req0_ready);
    end
    repeat (2) @(negedge clk);
    resetn = 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (UART_TXD !== 1'b1 || busy !== 1'b0 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: txd=%b busy=%b grant=%b, required 1 0 00", UART_TXD, busy, grant);
    end
  endtask

  task automatic test_single_55();
    int f, r0;
    f = frames_done; r0 = n_ready0;
    q_exp.push_back(8'h55);
    drive(0, 8'h55, 1);
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL single_grant_release: grant=%b, required 00", grant);
    end
    wait_frames(f + 1);
    n_checks++;
    if (n_ready0 - r0 != 1) begin
      n_fail++;
      $display("FAIL single_ready_pulses: got %0d, required 1", n_ready0 - r0);
    end
  endtask

  task automatic test_back_to_back();
    int f;
    do_reset();
    f = frames_done;
    q_exp.push_back(8'hA1);
    q_exp.push_back(8'hB2);
    fork
      drive(0, 8'hA1, 1);
      drive(1, 8'hB2, 1);
    join
    wait_frames(f + 2);
    n_checks++;
    if (last_start - prev_start != 41) begin
      n_fail++;
      $display("FAIL b2b_gap: frame spacing %0d, required 41", last_start - prev_start);
    end
  endtask

  task automatic test_packet();
    int f;
    do_reset();
    f = frames_done;
    q_exp.push_back(8'h41); q_exp.push_back(8'h42); q_exp.push_back(8'h43); q_exp.push_back(8'hC4);
    fork
      begin
        drive(0, 8'h41, 0);
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL packet_lock_1: grant=%b, required 01", grant); end
        drive(0, 8'h42, 0);
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL packet_lock_2: grant=%b, required 01", grant); end
        drive(0, 8'h43, 1);
      end
      drive(1, 8'hC4, 1);
    join
    wait_frames(f + 4);
  endtask

  task automatic test_timeout();
    int f, n;
    do_reset();
    f = frames_done;
    q_exp.push_back(8'h5A);
    q_exp.push_back(8'h77);
    drive(0, 8'h5A, 0);
    req1_valid = 1; req1_data = 8'h77; req1_last = 1;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    n = 0;
    while (grant === 2'b01 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n != 16 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_release: held %0d idle cycles then grant=%b, required 16 then 00", n, grant);
    end
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b10 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_regrant: grant=%b ready1=%b, required 10 and 1", grant, req1_ready);
    end
    @(posedge clk) #1;
    req1_valid = 0;
    wait_frames(f + 2);
  endtask

  task automatic test_reset_mid();
    int f;
    do_reset();
    q_exp.push_back(8'h3C);
    drive(0, 8'h3C, 1);
    repeat (17) @(negedge clk);
    #1 resetn = 0;
    #1;
    n_checks++;
    if (UART_TXD !== 1'b1 || busy !== 1'b0 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_midframe: txd=%b busy=%b grant=%b, required 1 0 00", UART_TXD, busy, grant);
    end
    q_exp.delete();
    repeat (2) @(negedge clk);
    resetn = 1;
    f = frames_done;
    q_exp.push_back(8'h96);
    drive(0, 8'h96, 1);
    wait_frames(f + 1);
  endtask

  task automatic test_ff();
    int f, lows;
    f = frames_done;
    q_exp.push_back(8'hFF);
    drive(1, 8'hFF, 1);
    lows = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (UART_TXD === 1'b0) lows++;
    end
    n_checks++;
    if (lows != 4) begin
      n_fail++;
      $display("FAIL ff_low_cycles: got %0d, required 4", lows);
    end
    wait_frames(f + 1);
  endtask

  initial begin
    test_reset();
    test_single_55();
    test_back_to_back();
    test_packet();
    test_timeout();
    test_reset_mid();
    test_ff();
    repeat (5) @(negedge clk);
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: %0d bytes never sent, required 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
